// File: rtl/cceip_64_if.sv
// Stream and APB bundles used on the cceip_64 boundary.
// One parameterised stream bundle serves inbound, outbound and completion channels.
interface cceip_64_axis_if #(
    parameter int DATA_W = 64,
    parameter int STRB_W = 8,
    parameter int USER_W = 8,
    parameter int ID_W   = 1
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [STRB_W-1:0] tstrb;
    logic [USER_W-1:0] tuser;
    logic [ID_W-1:0]   tid;
    logic              tlast;

    modport master (output tvalid, tdata, tstrb, tuser, tid, tlast, input tready);
    modport slave  (input tvalid, tdata, tstrb, tuser, tid, tlast, output tready);
endinterface

interface cceip_64_apb_if #(
    parameter int ADDR_W = 20
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    modport master (output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
    modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/cceip_64.sv
// Bypass-mode frame engine shell: forwards inbound frames through a small beat FIFO,
// measures data-frame payload, emits 4-byte completion messages, APB register block.
module cceip_64 #(
    parameter int TID_W      = 1,
    parameter int USER_W     = 8,
    parameter int ADDR_W     = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cceip_64_axis_if.slave         ib,
    cceip_64_axis_if.master        ob,
    cceip_64_axis_if.master        sch_update,
    cceip_64_apb_if.slave          apb,
    input  logic                   key_mode,
    input  logic                   dbg_cmd_disable,
    input  logic                   xp9_disable,
    output logic                   cceip_int,
    output logic                   cceip_idle,
    input  logic                   scan_en,
    input  logic                   scan_mode,
    input  logic                   scan_rst_n,
    input  logic                   ovstb,
    input  logic                   lvm,
    input  logic                   mlvm
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BEAT_W = 64 + 8 + USER_W + TID_W + 1;

    localparam logic [ADDR_W-1:0] A_ID     = ADDR_W'(32'h00);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(32'h04);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(32'h08);
    localparam logic [ADDR_W-1:0] A_INT    = ADDR_W'(32'h0C);
    localparam logic [ADDR_W-1:0] A_MASK   = ADDR_W'(32'h10);
    localparam logic [ADDR_W-1:0] A_FCNT   = ADDR_W'(32'h14);
    localparam logic [ADDR_W-1:0] A_LEN    = ADDR_W'(32'h18);

    typedef enum logic [1:0] {
        FR_IDLE  = 2'd0,
        FR_DATA  = 2'd1,
        FR_DBG   = 2'd2,
        FR_OTHER = 2'd3
    } frame_e;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

    frame_e                frame_q, frame_d;
    logic [BEAT_W-1:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic [31:0]           cnt_q, cnt_d;
    logic [31:0]           msg_q, msg_d;
    logic [1:0]            msg_idx_q, msg_idx_d;
    logic                  msg_pending_q, msg_pending_d;
    logic                  ctrl_en_q, ctrl_en_d;
    logic [1:0]            int_mask_q, int_mask_d;
    logic [1:0]            int_status_q, int_status_d;
    logic [31:0]           frame_cnt_q, frame_cnt_d;
    logic [31:0]           last_len_q, last_len_d;
    logic                  int_q, int_d;
    logic                  idle_q, idle_d;

    logic                  sot_s, eot_s, beat_data_s, beat_dbg_s, stall_s;
    logic                  ib_ready_s, ib_fire_s, push_s, pop_s, sch_fire_s;
    logic                  fifo_full_s, fifo_empty_s, proto_err_s, done_s;
    logic [31:0]           done_len_s;
    logic [3:0]            beat_bytes_s;
    logic                  apb_acc_s, apb_wr_s, unmapped_s;
    logic [31:0]           rdata_s;
    logic                  dft_unused_s;

    assign dft_unused_s = ^{scan_en, scan_mode, scan_rst_n, ovstb, lvm, mlvm, apb.pwdata[31:2]};

    // Inbound beat classification; a non-SoT beat inherits the type of the open frame.
    assign sot_s        = ib.tuser[0];
    assign eot_s        = ib.tuser[1];
    assign beat_data_s  = sot_s ? (ib.tdata[7:0] == 8'h05) : (frame_q == FR_DATA);
    assign beat_dbg_s   = sot_s ? (ib.tdata[7:0] == 8'h0b) : (frame_q == FR_DBG);
    assign stall_s      = msg_pending_q && ib.tvalid && eot_s && beat_data_s;
    assign fifo_full_s  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty_s = (count_q == '0);
    assign ib_ready_s   = rst_n && !fifo_full_s && ctrl_en_q && !stall_s;
    assign ib_fire_s    = ib.tvalid && ib_ready_s;
    assign push_s       = ib_fire_s && !(dbg_cmd_disable && beat_dbg_s);
    assign pop_s        = !fifo_empty_s && ob.tready;
    assign sch_fire_s   = msg_pending_q && sch_update.tready;
    assign beat_bytes_s = popcount8(ib.tstrb);
    assign ib.tready    = ib_ready_s;

    assign ob.tvalid = !fifo_empty_s;
    assign {ob.tdata, ob.tstrb, ob.tuser, ob.tid, ob.tlast} = mem_q[rd_ptr_q];

    assign sch_update.tvalid = msg_pending_q;
    assign sch_update.tdata  = msg_pending_q ? msg_q[8*msg_idx_q +: 8] : 8'h00;
    assign sch_update.tuser  = msg_pending_q ? {msg_idx_q == 2'd3, msg_idx_q == 2'd0} : 2'b00;
    assign sch_update.tlast  = msg_pending_q && (msg_idx_q == 2'd3);
    assign sch_update.tstrb  = '0;
    assign sch_update.tid    = '0;

    assign apb_acc_s   = apb.psel && apb.penable;
    assign apb_wr_s    = apb_acc_s && apb.pwrite && !unmapped_s;
    assign apb.pready  = rst_n && apb_acc_s;
    assign apb.pslverr = rst_n && apb_acc_s && unmapped_s;
    assign apb.prdata  = (rst_n && apb_acc_s) ? rdata_s : 32'h0;

    assign cceip_int  = int_q;
    assign cceip_idle = idle_q;

    // Frame tracker state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_q <= FR_IDLE;
        end else begin
            frame_q <= frame_d;
        end
    end

    // Frame tracker next state and protocol-error detection.
    always_comb begin
        frame_d     = frame_q;
        proto_err_s = 1'b0;
        if (ib_fire_s) begin
            if (sot_s) begin
                proto_err_s = (frame_q != FR_IDLE);
                if (eot_s) begin
                    frame_d = FR_IDLE;
                end else if (ib.tdata[7:0] == 8'h05) begin
                    frame_d = FR_DATA;
                end else if (ib.tdata[7:0] == 8'h0b) begin
                    frame_d = FR_DBG;
                end else begin
                    frame_d = FR_OTHER;
                end
            end else begin
                proto_err_s = (frame_q == FR_IDLE);
                if (eot_s) begin
                    frame_d = FR_IDLE;
                end else begin
                    frame_d = frame_q;
                end
            end
        end else begin
            frame_d = frame_q;
        end
    end

    // APB read mux and address decode.
    always_comb begin
        rdata_s    = 32'h0;
        unmapped_s = 1'b0;
        case (apb.paddr)
            A_ID:     rdata_s = 32'hCCE1_0064;
            A_CTRL:   rdata_s = {31'd0, ctrl_en_q};
            A_STATUS: rdata_s = {29'd0, xp9_disable, key_mode, idle_q};
            A_INT:    rdata_s = {30'd0, int_status_q};
            A_MASK:   rdata_s = {30'd0, int_mask_q};
            A_FCNT:   rdata_s = frame_cnt_q;
            A_LEN:    rdata_s = last_len_q;
            default:  unmapped_s = 1'b1;
        endcase
    end

    // Datapath next state: FIFO pointers, byte count, message buffer, registers.
    always_comb begin
        wr_ptr_d      = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d      = pop_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d       = count_q + (PTR_W+1)'(push_s) - (PTR_W+1)'(pop_s);
        cnt_d         = cnt_q;
        done_s        = 1'b0;
        done_len_s    = sot_s ? 32'd0 : cnt_q + {28'd0, beat_bytes_s};
        msg_d         = msg_q;
        msg_idx_d     = msg_idx_q;
        msg_pending_d = msg_pending_q;
        ctrl_en_d     = ctrl_en_q;
        int_mask_d    = int_mask_q;
        int_status_d  = int_status_q;
        frame_cnt_d   = frame_cnt_q;
        last_len_d    = last_len_q;

        if (ib_fire_s && beat_data_s) begin
            cnt_d  = done_len_s;
            done_s = eot_s;
        end else begin
            cnt_d = cnt_q;
        end

        if (sch_fire_s) begin
            msg_idx_d     = msg_idx_q + 2'd1;
            msg_pending_d = (msg_idx_q != 2'd3);
        end else begin
            msg_idx_d = msg_idx_q;
        end

        // A new completion can only arrive while the buffer is free; stall guarantees it.
        if (done_s) begin
            msg_d         = done_len_s;
            msg_idx_d     = 2'd0;
            msg_pending_d = 1'b1;
            last_len_d    = done_len_s;
            frame_cnt_d   = frame_cnt_q + 32'd1;
        end else begin
            msg_d = msg_q;
        end

        if (apb_wr_s && (apb.paddr == A_CTRL)) begin
            ctrl_en_d = apb.pwdata[0];
        end else if (apb_wr_s && (apb.paddr == A_MASK)) begin
            int_mask_d = apb.pwdata[1:0];
        end else if (apb_wr_s && (apb.paddr == A_INT)) begin
            int_status_d = int_status_q & ~apb.pwdata[1:0];
        end else begin
            int_status_d = int_status_q;
        end

        // Set after clear so a same-cycle event beats the W1C.
        if (done_s) begin
            int_status_d[0] = 1'b1;
        end else begin
            int_status_d[0] = int_status_d[0];
        end
        if (proto_err_s) begin
            int_status_d[1] = 1'b1;
        end else begin
            int_status_d[1] = int_status_d[1];
        end

        int_d  = |(int_status_d & ~int_mask_d);
        idle_d = (count_d == '0) && (frame_d == FR_IDLE) && !msg_pending_d;
    end

    // Beat FIFO storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= {ib.tdata, ib.tstrb, ib.tuser, ib.tid, ib.tlast};
        end
    end

    // Control, status and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            cnt_q         <= 32'd0;
            msg_q         <= 32'd0;
            msg_idx_q     <= 2'd0;
            msg_pending_q <= 1'b0;
            ctrl_en_q     <= 1'b1;
            int_mask_q    <= 2'b00;
            int_status_q  <= 2'b00;
            frame_cnt_q   <= 32'd0;
            last_len_q    <= 32'd0;
            int_q         <= 1'b0;
            idle_q        <= 1'b1;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            cnt_q         <= cnt_d;
            msg_q         <= msg_d;
            msg_idx_q     <= msg_idx_d;
            msg_pending_q <= msg_pending_d;
            ctrl_en_q     <= ctrl_en_d;
            int_mask_q    <= int_mask_d;
            int_status_q  <= int_status_d;
            frame_cnt_q   <= frame_cnt_d;
            last_len_q    <= last_len_d;
            int_q         <= int_d;
            idle_q        <= idle_d;
        end
    end
endmodule

// File: tb/tb_cceip_64.sv
// Self-checking bench for cceip_64: directed scenarios plus randomized frames
// checked against a frame-level reference model (expected beat and message queues).
module tb_cceip_64;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic key_mode, dbg_cmd_disable, xp9_disable, cceip_int, cceip_idle;

    cceip_64_axis_if #(.DATA_W(64), .STRB_W(8), .USER_W(8), .ID_W(1)) ib_if ();
    cceip_64_axis_if #(.DATA_W(64), .STRB_W(8), .USER_W(8), .ID_W(1)) ob_if ();
    cceip_64_axis_if #(.DATA_W(8),  .STRB_W(1), .USER_W(2), .ID_W(1)) sch_if ();
    cceip_64_apb_if  #(.ADDR_W(20)) apb_if ();

    cceip_64 #(.TID_W(1), .USER_W(8), .ADDR_W(20), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .ib(ib_if), .ob(ob_if), .sch_update(sch_if), .apb(apb_if),
        .key_mode(key_mode), .dbg_cmd_disable(dbg_cmd_disable), .xp9_disable(xp9_disable),
        .cceip_int(cceip_int), .cceip_idle(cceip_idle),
        .scan_en(1'b0), .scan_mode(1'b0), .scan_rst_n(1'b1), .ovstb(1'b0), .lvm(1'b0), .mlvm(1'b0)
    );

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  s;
        logic [7:0]  u;
        logic        id;
        logic        l;
    } beat_t;

    int          checks = 0;
    int          errors = 0;
    beat_t       exp_ob[$];
    logic [10:0] exp_sch[$];
    logic [31:0] m_frame_cnt = 32'd0;
    logic [31:0] m_last_len  = 32'd0;
    int          acc_cnt = 0;
    bit          ob_rand = 1'b0, sch_rand = 1'b0;
    logic        ob_rdy_v = 1'b1, sch_rdy_v = 1'b1;
    beat_t       prev_ob;
    bit          prev_hold = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Downstream ready generators.
    always @(posedge clk) begin
        #1;
        ob_if.tready  = ob_rand  ? 1'($urandom_range(0, 1)) : ob_rdy_v;
        sch_if.tready = sch_rand ? 1'($urandom_range(0, 1)) : sch_rdy_v;
    end

    // Outbound and completion monitors against the model queues.
    always @(negedge clk) begin
        beat_t cur, e;
        logic [10:0] es;
        if (rst_n) begin
            cur = '{ob_if.tdata, ob_if.tstrb, ob_if.tuser, ob_if.tid, ob_if.tlast};
            if (ib_if.tvalid && ib_if.tready) acc_cnt++;
            if (prev_hold) chk("ob_hold", cur, prev_ob);
            prev_hold = ob_if.tvalid && !ob_if.tready;
            prev_ob   = cur;
            if (ob_if.tvalid && ob_if.tready) begin
                if (exp_ob.size() == 0) chk("ob_unexpected_beat", cur, 128'd0);
                else begin
                    e = exp_ob.pop_front();
                    chk("ob_beat", cur, e);
                end
            end
            if (sch_if.tvalid && sch_if.tready) begin
                if (exp_sch.size() == 0) chk("sch_unexpected_byte", {sch_if.tuser, sch_if.tlast, sch_if.tdata}, 128'h7FF_FFFF);
                else begin
                    es = exp_sch.pop_front();
                    chk("sch_byte", {sch_if.tuser, sch_if.tlast, sch_if.tdata}, es);
                end
            end
        end
    end

    task automatic model_done(input logic [31:0] len);
        exp_sch.push_back({2'b01, 1'b0, len[7:0]});
        exp_sch.push_back({2'b00, 1'b0, len[15:8]});
        exp_sch.push_back({2'b00, 1'b0, len[23:16]});
        exp_sch.push_back({2'b10, 1'b1, len[31:24]});
        m_frame_cnt = m_frame_cnt + 32'd1;
        m_last_len  = len;
    endtask

    task automatic send_beat(input beat_t b);
        logic rdy;
        ib_if.tvalid = 1'b1;
        ib_if.tdata  = b.d;
        ib_if.tstrb  = b.s;
        ib_if.tuser  = b.u;
        ib_if.tid    = b.id;
        ib_if.tlast  = b.l;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            rdy = ib_if.tready;
            @(posedge clk);
            #1;
            if (rdy) break;
            if (n > 3000) begin
                chk("ib_accept_timeout", 128'd0, 128'd1);
                break;
            end
        end
        ib_if.tvalid = 1'b0;
    endtask

    // Well-formed frame of nb beats; the model decides drop, length and completion.
    task automatic send_frame(input logic [7:0] ftype, input int nb, input bit full);
        beat_t       b;
        logic [31:0] len;
        bit          drop;
        len  = 32'd0;
        drop = dbg_cmd_disable && (ftype == 8'h0b);
        for (int i = 0; i < nb; i++) begin
            b.d = {$urandom, $urandom};
            if (i == 0) b.d[7:0] = ftype;
            b.s  = full ? ((i == nb - 1 && i != 0) ? 8'h0F : 8'hFF) : 8'($urandom);
            b.u  = {6'd0, i == nb - 1, i == 0};
            b.id = 1'($urandom);
            b.l  = (i == nb - 1);
            if (i > 0) len = len + $countones(b.s);
            if (!drop) exp_ob.push_back(b);
            if (ftype == 8'h05 && i == nb - 1) model_done(len);
            send_beat(b);
        end
    endtask

    task automatic send_raw(input logic [7:0] ftype, input logic [7:0] u);
        beat_t b;
        b.d = {$urandom, $urandom};
        b.d[7:0] = ftype;
        b.s = 8'hFF; b.u = u; b.id = 1'b0; b.l = u[1];
        exp_ob.push_back(b);
        send_beat(b);
    endtask

    task automatic apb_rd(input logic [19:0] a, output logic [31:0] d, output logic err);
        apb_if.psel = 1'b1; apb_if.penable = 1'b0; apb_if.pwrite = 1'b0; apb_if.paddr = a;
        @(posedge clk); #1;
        apb_if.penable = 1'b1;
        @(negedge clk);
        d = apb_if.prdata; err = apb_if.pslverr;
        chk("apb_rd_pready", apb_if.pready, 1'b1);
        @(posedge clk); #1;
        apb_if.psel = 1'b0; apb_if.penable = 1'b0;
    endtask

    task automatic apb_wr(input logic [19:0] a, input logic [31:0] d);
        apb_if.psel = 1'b1; apb_if.penable = 1'b0; apb_if.pwrite = 1'b1; apb_if.paddr = a; apb_if.pwdata = d;
        @(posedge clk); #1;
        apb_if.penable = 1'b1;
        @(negedge clk);
        chk("apb_wr_pready", apb_if.pready, 1'b1);
        @(posedge clk); #1;
        apb_if.psel = 1'b0; apb_if.penable = 1'b0; apb_if.pwrite = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [19:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        err;
        apb_rd(a, d, err);
        chk(tag, {err, d}, {1'b0, exp});
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (cceip_idle && exp_ob.size() == 0 && exp_sch.size() == 0) break;
        end
        if (n >= 2000) chk("drain_timeout", 128'd0, 128'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] d;
        logic        err;
        int          a0;
        rst_n = 1'b0;
        key_mode = 1'b1; xp9_disable = 1'b0; dbg_cmd_disable = 1'b0;
        ib_if.tvalid = 1'b0; ib_if.tdata = 64'd0; ib_if.tstrb = 8'd0;
        ib_if.tuser = 8'd0; ib_if.tid = 1'b0; ib_if.tlast = 1'b0;
        apb_if.psel = 1'b1; apb_if.penable = 1'b1; apb_if.pwrite = 1'b0;
        apb_if.paddr = 20'h0; apb_if.pwdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ib_tready", ib_if.tready, 1'b0);
        chk("rst_ob_tvalid", ob_if.tvalid, 1'b0);
        chk("rst_ob_tdata", ob_if.tdata, 64'd0);
        chk("rst_sch_tvalid", sch_if.tvalid, 1'b0);
        chk("rst_pready", {apb_if.pready, apb_if.pslverr}, 2'b00);
        chk("rst_int_idle", {cceip_int, cceip_idle}, 2'b01);
        apb_if.psel = 1'b0; apb_if.penable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        rd_chk("id", 20'h00, 32'hCCE10064);
        apb_rd(20'h40, d, err);
        chk("unmapped_slverr", err, 1'b1);
        rd_chk("ctrl_reset", 20'h04, 32'h1);
        rd_chk("status_idle", 20'h08, 32'h3);

        // Directed data frame: 3 full beats after SoT plus a 4-byte tail.
        send_frame(8'h05, 5, 1'b1);
        wait_idle();
        rd_chk("last_len_28", 20'h18, 32'd28);
        rd_chk("frame_cnt_1", 20'h14, 32'd1);
        rd_chk("int_status_done", 20'h0C, 32'h1);
        chk("int_after_frame", cceip_int, 1'b1);

        apb_wr(20'h0C, 32'h1);
        @(posedge clk); #1;
        chk("int_after_w1c", cceip_int, 1'b0);
        apb_wr(20'h10, 32'h1);
        send_frame(8'h05, 5, 1'b1);
        wait_idle();
        chk("int_masked", cceip_int, 1'b0);
        rd_chk("int_status_masked", 20'h0C, 32'h1);
        rd_chk("frame_cnt_2", 20'h14, m_frame_cnt);

        // Debug drop, then forwarding with the strap cleared.
        dbg_cmd_disable = 1'b1;
        send_frame(8'h0b, 1, 1'b1);
        send_frame(8'h0b, 3, 1'b0);
        wait_idle();
        dbg_cmd_disable = 1'b0;
        send_frame(8'h0b, 1, 1'b1);
        wait_idle();

        // Outbound backpressure on a 20-beat frame.
        ob_rdy_v = 1'b0;
        @(posedge clk); #1;
        a0 = acc_cnt;
        fork
            send_frame(8'h05, 20, 1'b0);
        join_none
        repeat (10) @(posedge clk);
        #2;
        chk("bp_accepted_4", acc_cnt - a0, 4);
        chk("bp_ib_tready_low", ib_if.tready, 1'b0);
        chk("bp_not_idle", cceip_idle, 1'b0);
        ob_rdy_v = 1'b1;
        wait fork;
        wait_idle();
        chk("bp_idle_after_drain", cceip_idle, 1'b1);

        // Back-to-back data frames with the completion channel blocked.
        sch_rdy_v = 1'b0;
        fork
            begin
                send_frame(8'h05, 3, 1'b0);
                send_frame(8'h05, 4, 1'b0);
            end
        join_none
        repeat (40) @(posedge clk);
        #2;
        chk("b2b_stall_on_eot", {ib_if.tvalid, ib_if.tready, ib_if.tuser}, {1'b1, 1'b0, 8'h02});
        chk("b2b_sch_pending", {sch_if.tvalid, cceip_idle}, 2'b10);
        sch_rdy_v = 1'b1;
        wait fork;
        wait_idle();
        rd_chk("b2b_last_len", 20'h18, m_last_len);
        rd_chk("b2b_frame_cnt", 20'h14, m_frame_cnt);

        // Enable gating.
        apb_wr(20'h04, 32'h0);
        @(negedge clk);
        chk("disabled_tready", ib_if.tready, 1'b0);
        rd_chk("ctrl_cleared", 20'h04, 32'h0);
        apb_wr(20'h04, 32'h1);
        @(negedge clk);
        chk("enabled_tready", ib_if.tready, 1'b1);
        @(posedge clk); #1;

        // Protocol errors: orphan beat, then SoT inside an open frame.
        apb_wr(20'h0C, 32'h3);
        send_raw(8'h05, 8'h00);
        wait_idle();
        rd_chk("proto_orphan", 20'h0C, 32'h2);
        chk("proto_int", cceip_int, 1'b1);
        apb_wr(20'h0C, 32'h3);
        send_raw(8'h05, 8'h01);
        send_raw(8'h07, 8'h01);
        send_raw(8'h07, 8'h02);
        wait_idle();
        rd_chk("proto_resot", 20'h0C, 32'h2);
        rd_chk("proto_frame_cnt", 20'h14, m_frame_cnt);

        // Randomized frames under random backpressure.
        ob_rand = 1'b1;
        sch_rand = 1'b1;
        for (int f = 0; f < 30; f++) begin
            logic [7:0] types [4];
            types[0] = 8'h05; types[1] = 8'h05; types[2] = 8'h0b; types[3] = 8'h07;
            dbg_cmd_disable = 1'($urandom_range(0, 1));
            send_frame(types[$urandom_range(0, 3)], $urandom_range(1, 6), 1'b0);
        end
        wait_idle();
        ob_rand = 1'b0;
        sch_rand = 1'b0;
        rd_chk("rand_frame_cnt", 20'h14, m_frame_cnt);
        rd_chk("rand_last_len", 20'h18, m_last_len);
        chk("rand_idle", cceip_idle, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
